// File: rtl/fxp_add_pipe_pkg.sv
// Shared op encoding and fixed-point helpers for the multi-lane add/sub/accumulate pipe.
// The 64-bit working width holds any legal aligned operand plus guard bits.
package fxp_pkg;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_ACC  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  localparam int FXP_IW = 64;

  typedef logic signed [FXP_IW-1:0] fxp_wide_t;

  typedef struct packed {
    fxp_wide_t val;
    logic      flag;
  } fxp_sat_t;

  // s > 0 moves the binary point right (exact); s < 0 drops fraction bits,
  // optionally adding half an LSB first so the arithmetic shift rounds half-up.
  function automatic fxp_wide_t fxp_align(fxp_wide_t x, int s, bit rnd);
    fxp_wide_t r;
    if (s >= 0) begin
      r = x <<< s;
    end else begin
      r = x;
      if (rnd) r = r + (fxp_wide_t'(1) <<< (-s - 1));
      r = r >>> (-s);
    end
    return r;
  endfunction

  function automatic fxp_sat_t fxp_sat(fxp_wide_t x, int out_w);
    fxp_wide_t hi;
    fxp_wide_t lo;
    fxp_sat_t  r;
    hi     = (fxp_wide_t'(1) <<< (out_w - 1)) - fxp_wide_t'(1);
    lo     = -hi - fxp_wide_t'(1);
    r.flag = 1'b1;
    if (x > hi) begin
      r.val = hi;
    end else if (x < lo) begin
      r.val = lo;
    end else begin
      r.val  = x;
      r.flag = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_add_pipe_if.sv
// Valid/ready beat bus for fxp_add_pipe: input operands/op upstream, saturated lanes downstream.
interface fxp_add_pipe_if #(
  parameter int LANES     = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 op;
  logic [LANES*A_WIDTH-1:0]   a_in;
  logic [LANES*B_WIDTH-1:0]   b_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*OUT_WIDTH-1:0] out;
  logic [LANES-1:0]           sat_flag;

  modport master (
    output in_valid, op, a_in, b_in, out_ready,
    input  in_ready, out_valid, out, sat_flag
  );

  modport slave (
    input  in_valid, op, a_in, b_in, out_ready,
    output in_ready, out_valid, out, sat_flag
  );
endinterface

// File: rtl/fxp_add_pipe_lane_alu.sv
// One lane: align both operands to the output format, add/sub/accumulate, clamp.
module fxp_lane_alu
  import fxp_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int A_FRAC    = 8,
  parameter int B_WIDTH   = 16,
  parameter int B_FRAC    = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 8,
  parameter int ROUND     = 1
) (
  input  logic [1:0]                  op,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic signed [OUT_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] res,
  output logic                        sat
);

  fxp_wide_t a_al;
  fxp_wide_t b_al;
  fxp_wide_t sum;
  fxp_sat_t  clamped;

  always_comb begin
    a_al = fxp_align(fxp_wide_t'(a), OUT_FRAC - A_FRAC, ROUND != 0);
    b_al = fxp_align(fxp_wide_t'(b), OUT_FRAC - B_FRAC, ROUND != 0);
    case (op)
      OP_ADD:  sum = a_al + b_al;
      OP_SUB:  sum = a_al - b_al;
      OP_ACC:  sum = fxp_wide_t'(acc) + a_al;
      default: sum = a_al;
    endcase
    clamped = fxp_sat(sum, OUT_WIDTH);
    res     = OUT_WIDTH'(clamped.val);
    sat     = clamped.flag;
  end

endmodule

// File: rtl/fxp_add_pipe.sv
// Multi-lane saturating add/sub/accumulate with a DEPTH-stage valid/ready pipeline.
// Define FXP_ADD_STATS_EN to build the saturation event counter; otherwise sat_count is 0.
module fxp_add_pipe
  import fxp_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int A_WIDTH   = 16,
  parameter int A_FRAC    = 8,
  parameter int B_WIDTH   = 16,
  parameter int B_FRAC    = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 8,
  parameter int DEPTH     = 2,
  parameter int ROUND     = 1
) (
  input  logic          clk,
  input  logic          reset,
  fxp_add_pipe_if.slave bus,
  output logic [15:0]   sat_count
);

  logic [OUT_WIDTH-1:0]       acc_q [LANES];
  logic [LANES*OUT_WIDTH-1:0] res_c;
  logic [LANES-1:0]           sat_c;
  logic [DEPTH-1:0]           v_q;
  logic [DEPTH-1:0]           ld;
  logic [LANES*OUT_WIDTH-1:0] d_q [DEPTH];
  logic [LANES-1:0]           f_q [DEPTH];
  logic                       fire;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fxp_lane_alu #(
      .A_WIDTH(A_WIDTH), .A_FRAC(A_FRAC), .B_WIDTH(B_WIDTH), .B_FRAC(B_FRAC),
      .OUT_WIDTH(OUT_WIDTH), .OUT_FRAC(OUT_FRAC), .ROUND(ROUND)
    ) u_alu (
      .op  (bus.op),
      .a   (bus.a_in[i*A_WIDTH +: A_WIDTH]),
      .b   (bus.b_in[i*B_WIDTH +: B_WIDTH]),
      .acc (acc_q[i]),
      .res (res_c[i*OUT_WIDTH +: OUT_WIDTH]),
      .sat (sat_c[i])
    );
  end

  // A stage may load when it is empty or its successor takes its beat this cycle.
  always_comb begin
    ld = '0;
    ld[DEPTH-1] = !v_q[DEPTH-1] || bus.out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      ld[k] = !v_q[k] || ld[k+1];
    end
  end

  assign bus.in_ready  = ld[0] && !reset;
  assign fire          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out       = d_q[DEPTH-1];
  assign bus.sat_flag  = f_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
        f_q[k] <= '0;
      end
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      if (ld[0]) begin
        v_q[0] <= fire;
        if (fire) begin
          d_q[0] <= res_c;
          f_q[0] <= sat_c;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
          f_q[k] <= f_q[k-1];
        end
      end
      // Accumulators follow accepted beats only, independent of output stalls.
      if (fire && (bus.op == OP_ACC || bus.op == OP_LOAD)) begin
        for (int l = 0; l < LANES; l++) acc_q[l] <= res_c[l*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

`ifdef FXP_ADD_STATS_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, cnt_q} + 17'($countones(f_q[DEPTH-1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (v_q[DEPTH-1] && bus.out_ready) begin
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule
